// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between the execute-stage requesters
//   (0 = branch, 1 = integer execute, 2 = load/store). One op is in flight at
//   a time: the winner's operands are latched and driven onto the tri-stated
//   ALU input bus for one BUSY cycle. The ALU result is then captured and a
//   one-hot done pulse is raised.
//
//   Configuration macro: ALU_ARB_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration (pointer starts at 0)
//     undefined -> fixed priority, lowest index wins (no pointer register)
//
//   Ports
//     clk, reset_n        clock, async active-low reset
//     enable_n            active-low issue enable (in-flight op always completes)
//     req/req_a/req_b/req_op  per-requester request and operands (sliced by index)
//     grant               registered one-hot grant, zero when idle
//     done                one-cycle one-hot completion pulse
//     result              captured ALU result, holds between ops
//     alu_a/alu_b/alu_op  ALU inputs, high-Z unless BUSY
//     alu_out             combinational ALU result
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]    req_op,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [XLEN-1:0]         result,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [2:0]              alu_op,
  input  logic [XLEN-1:0]         alu_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic [XLEN-1:0]      r_result;
  logic [XLEN-1:0]      r_a;
  logic [XLEN-1:0]      r_b;
  logic [2:0]           r_op;

  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_found;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_ptr;
  logic                 w_issue;

  // The previous winner still holds req during DONE, so mask it out.
  always_comb begin
    w_elig  = req & ((r_state == S_DONE) ? ~r_grant : {NUM_REQ{1'b1}});
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(w_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  assign w_issue = w_found && !enable_n && (r_state != S_BUSY);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + PW'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_BUSY: begin
          r_result <= alu_out;
          r_done   <= r_grant;
          r_state  <= S_DONE;
        end
        default: begin  // IDLE and DONE share the issue path
          if (w_issue) begin
            r_a     <= req_a[int'(w_win)*XLEN +: XLEN];
            r_b     <= req_b[int'(w_win)*XLEN +: XLEN];
            r_op    <= req_op[int'(w_win)*3 +: 3];
            r_grant <= NUM_REQ'(1) << w_win;
            r_state <= S_BUSY;
          end else begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign grant  = r_grant;
  assign done   = r_done;
  assign result = r_result;

  // Operands come from the latched copy so requesters may change theirs
  // after the grant.
  assign alu_a  = (r_state == S_BUSY) ? r_a  : {XLEN{1'bz}};
  assign alu_b  = (r_state == S_BUSY) ? r_b  : {XLEN{1'bz}};
  assign alu_op = (r_state == S_BUSY) ? r_op : 3'bzzz;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int XLEN = 32;
  localparam int N    = 3;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            enable_n = 1'b0;
  logic [N-1:0]      req    = '0;
  logic [N*XLEN-1:0] req_a  = '0;
  logic [N*XLEN-1:0] req_b  = '0;
  logic [N*3-1:0]    req_op = '0;
  wire  [N-1:0]    grant, done;
  wire  [XLEN-1:0] result, alu_a, alu_b, alu_out;
  wire  [2:0]      alu_op;

  alu_arbiter #(.XLEN(XLEN), .NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .enable_n(enable_n),
    .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .grant(grant), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_f(logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return {31'b0, ($signed(a) < $signed(b))};
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_op);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // A floating bus may read back as Z or, in a two-state simulator, as 0.
  task automatic chk_hz(input string name, input logic [XLEN-1:0] act, input int w);
    bit all_z = 1'b1;
    bit all_0 = 1'b1;
    vectors++;
    for (int i = 0; i < w; i++) begin
      if (act[i] !== 1'bz) all_z = 1'b0;
      if (act[i] !== 1'b0) all_0 = 1'b0;
    end
    if (!(all_z || all_0)) begin
      miscompares++;
      $display("FAIL %s: got %h want high-Z at %0t", name, act, $time);
    end
  endtask

  // Model: who owns the ALU and which phase of the two-cycle op it is in.
  int              m_phase = 0;   // 0 free, 1 operands on bus, 2 completing
  int              m_w     = 0;
  int              m_ptr   = 0;
  logic [XLEN-1:0] m_a, m_b, m_res;
  logic [2:0]      m_op;
  bit              chk_on  = 1'b0;

  function automatic int pick(input logic [N-1:0] e, input int p);
    for (int k = 0; k < N; k++)
      if (e[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic take(input logic [N-1:0] e);
    m_w   = pick(e, m_ptr);
    m_a   = req_a[m_w*XLEN +: XLEN];
    m_b   = req_b[m_w*XLEN +: XLEN];
    m_op  = req_op[m_w*3 +: 3];
    m_ptr = RR ? (m_w + 1) % N : 0;
    m_phase = 1;
  endtask

  initial begin
    m_a = '0; m_b = '0; m_res = '0; m_op = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_phase = 0; m_w = 0; m_ptr = 0; m_res = '0;
      end else if (m_phase == 1) begin
        m_res   = alu_f(m_a, m_b, m_op);
        m_phase = 2;
      end else begin
        logic [N-1:0] e;
        e = req;
        if (m_phase == 2) e[m_w] = 1'b0;
        if (!enable_n && e != '0) take(e);
        else m_phase = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && chk_on) begin
        logic [N-1:0] eg, ed;
        eg = (m_phase != 0) ? (N'(1) << m_w) : '0;
        ed = (m_phase == 2) ? (N'(1) << m_w) : '0;
        chk("grant", XLEN'(grant), XLEN'(eg));
        chk("done", XLEN'(done), XLEN'(ed));
        chk("result", result, m_res);
        if (m_phase == 1) begin
          chk("alu_a", alu_a, m_a);
          chk("alu_b", alu_b, m_b);
          chk("alu_op", XLEN'(alu_op), XLEN'(m_op));
        end else begin
          chk_hz("alu_a_z", alu_a, XLEN);
          chk_hz("alu_b_z", alu_b, XLEN);
          chk_hz("alu_op_z", XLEN'(alu_op), 3);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [2:0] op);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_op[i*3 +: 3]      = op;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
  endtask

  logic [N-1:0] seq_exp [4];

  initial begin
    cyc(2);
    chk("rst_grant", XLEN'(grant), '0);
    chk("rst_result", result, '0);
    chk_hz("rst_alu_a", alu_a, XLEN);
    reset_n = 1'b1;
    chk_on  = 1'b1;

    // Lone add: 5 + 3
    set_req(0, 32'h5, 32'h3, 3'd0);
    req = 3'b001;
    cyc(1);
    chk("t1_grant", XLEN'(grant), 32'h1);
    chk("t1_alu_a", alu_a, 32'h5);
    chk("t1_alu_b", alu_b, 32'h3);
    cyc(1);
    chk("t1_done", XLEN'(done), 32'h1);
    chk("t1_result", result, 32'h8);
    chk_hz("t1_alu_a_done", alu_a, XLEN);
    req = '0;
    cyc(1);
    chk("t1_idle_grant", XLEN'(grant), '0);
    chk_hz("t1_alu_a_idle", alu_a, XLEN);

    // Full contention
    do_reset();
    set_req(0, 32'h0000_0100, 32'h0000_0001, 3'd1);
    set_req(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2);
    set_req(2, 32'hAAAA_5555, 32'hFFFF_0000, 3'd4);
    if (RR) seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    else    seq_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
    req = 3'b111;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (k % 2 == 1) chk("t2_done_seq", XLEN'(done), XLEN'(seq_exp[k/2]));
      else            chk("t2_no_idle", XLEN'(grant == '0), '0);
    end
    chk("t2_first_result", 32'h0000_0100 - 32'h1, 32'h0000_00FF);
    chk("t2_result", result, RR ? 32'h0000_00FF : 32'h00F0_00F0);
    req = '0;
    cyc(2);

    // Disabled, then enabled
    enable_n = 1'b1;
    set_req(1, 32'h10, 32'h3, 3'd1);
    req = 3'b010;
    cyc(2);
    chk("t3_no_grant", XLEN'(grant), '0);
    chk_hz("t3_alu_a_z", alu_a, XLEN);
    enable_n = 1'b0;
    cyc(1);
    chk("t3_grant", XLEN'(grant), 32'h2);
    chk("t3_alu_a", alu_a, 32'h10);
    cyc(1);
    chk("t3_done", XLEN'(done), 32'h2);
    chk("t3_result", result, 32'hD);
    req = '0;
    cyc(1);

    // enable_n rises while BUSY: op finishes, no further grant
    req = 3'b010;
    cyc(1);
    enable_n = 1'b1;
    req = 3'b011;
    cyc(1);
    chk("t4_done", XLEN'(done), 32'h2);
    cyc(1);
    chk("t4_grant_off", XLEN'(grant), '0);
    req = '0;
    enable_n = 1'b0;
    cyc(2);

    // Reset in the middle of an op
    set_req(2, 32'h1234_0000, 32'h0000_5678, 3'd3);
    req = 3'b100;
    cyc(1);
    chk("t5_grant", XLEN'(grant), 32'h4);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_grant", XLEN'(grant), '0);
    chk("t5_rst_done", XLEN'(done), '0);
    chk("t5_rst_result", result, '0);
    chk_hz("t5_rst_alu_a", alu_a, XLEN);
    chk_hz("t5_rst_alu_op", XLEN'(alu_op), 3);
    req = '0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    chk("t5_no_done1", XLEN'(done), '0);
    cyc(1);
    chk("t5_no_done2", XLEN'(done), '0);

    // Winner drops req during BUSY: FFFF_FFFF + 1 wraps to 0
    set_req(2, 32'hFFFF_FFFF, 32'h1, 3'd0);
    req = 3'b100;
    cyc(1);
    chk("t6_grant", XLEN'(grant), 32'h4);
    req = '0;
    cyc(1);
    chk("t6_done", XLEN'(done), 32'h4);
    chk("t6_result", result, 32'h0);
    cyc(1);
    chk("t6_idle", XLEN'(grant), '0);
    chk("t6_done_off", XLEN'(done), '0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
